fb_port_arbiter: RTL
====================

Name: fb_port_arbiter

Overview:
- Shares framebuffer BRAM port A (byte-addressed, 32-bit words, 1-cycle read latency) between two requesters: m0 = CPU bus bridge, m1 = blitter/DMA engine.
- Sits between the requesters and the port A inputs of vga_controller; the VGA scan-out port B is unaffected.
- Provides per-requester valid/grant handshakes, selectable fixed-priority or round-robin arbitration, starvation protection, and in-order read-data return with owner tagging.

Parameters:
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority with m0 highest.
- MAX_STARVE, 16, in fixed mode: number of consecutive waiting cycles after which m1 wins the next contention (range 1..255).
- READ_LATENCY, 1, BRAM port A read latency in cycles (range 1..3).
- FB_BYTES, 307200, framebuffer size in bytes (640x480 at 8bpp).

Ports:
- clk  in  1  system clock; also drives the BRAM port A clock.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  1  requester 0 command valid.
- m0_we  in  4  requester 0 byte write enables; 0 = read.
- m0_addr  in  19  requester 0 byte address.
- m0_wdata  in  32  requester 0 write data.
- m0_gnt  out  1  requester 0 command accepted this cycle (combinational).
- m0_rvalid  out  1  requester 0 read data valid, 1-cycle pulse.
- m0_rdata  out  32  requester 0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same widths and meanings, for requester 1.
- bram_clka  out  1  equal to clk.
- bram_rsta  out  1  equal to reset.
- bram_ena  out  1  port A enable (registered).
- bram_wea  out  4  port A byte write enables (registered).
- bram_addra  out  19  port A byte address (registered); the BRAM uses bits [18:2].
- bram_dina  out  32  port A write data (registered).
- bram_douta  in  32  port A read data.

Behaviour:
- Reset values: all gnt, rvalid, bram_ena and bram_wea = 0; bram_addra = 0, bram_dina = 0, all rdata = 0; last_grant = 1 (so m0 wins the first contention); starve counter = 0; all in-flight read tags cleared.
- Handshake:
  - A requester holds req, we, addr and wdata stable until it sees gnt high.
  - Acceptance happens at the clock edge where req && gnt.
  - At most one grant per cycle; throughput is one command per cycle with no bubbles.
- Arbitration, when exactly one requester asks: it is granted.
- Arbitration, when both ask:
  - ARB_MODE=0: grant the requester that is not last_grant.
  - ARB_MODE=1: grant m0, unless starve count >= MAX_STARVE, in which case grant m1.
  - last_grant updates on every grant.
- Starve counter:
  - Increments (saturating at 255) each cycle m1_req && !m1_gnt.
  - Clears on m1 grant or when m1_req is low.
  - Ignored in ARB_MODE=0.
- Issue stage, command accepted at edge N:
  - bram_ena=1 and bram_addra/bram_wea/bram_dina hold the command during cycle N+1.
  - bram_ena=0 and bram_wea=0 when nothing was accepted.
- Out-of-range (addr >= FB_BYTES):
  - Still granted; bram_ena=0 for that slot.
  - A write is dropped.
  - A read returns rdata=0 with a normal rvalid at the normal time.
- Read return:
  - A tag shift register of depth READ_LATENCY+1 carries {valid, owner, oob} per slot.
  - For a read accepted at edge N, the owner's rvalid is high for exactly one cycle, N+2+READ_LATENCY.
  - rdata is the registered bram_douta (or 0 if oob) and holds its value until the next rvalid for that owner.
  - The non-owner's rvalid stays 0.
- Writes never generate rvalid. Reads return in acceptance order.
- Read-after-write to the same address, accepted in consecutive cycles: the read returns the new data (the BRAM is configured read-first per cycle and the write lands one cycle earlier).
- Reset mid-operation: all in-flight tags are discarded; no rvalid appears in the cycle after reset is sampled, or later, for commands accepted before it.
- Requests present during reset are not granted.

Test Plan:
- Single m0 write, we=4'hF, addr=0x00010, wdata=0xA1B2C3D4: bram_ena=1, wea=F, addra=0x00010 one cycle after gnt. Then an m0 read of 0x00010: m0_rvalid exactly 3 cycles after gnt with rdata=0xA1B2C3D4; m1_rvalid stays 0.
- ARB_MODE=0, both requesting continuously for 8 cycles: grants alternate m0,m1,m0,...; first grant goes to m0; 8 grants in 8 cycles.
- ARB_MODE=1, MAX_STARVE=4, both requesting continuously: m0 granted 4 consecutive cycles, m1 granted on the 5th, then the pattern repeats.
- m1 read at addr=307200 (out of range): m1_gnt=1, bram_ena stays 0, m1_rvalid pulses 3 cycles later with rdata=0.
- Back-to-back m0 write 0x55 to byte lane 2 (we=4'b0100, addr=0x00100), then m1 read of 0x00100: m1_rdata[23:16]=0x55, other bytes unchanged.
- Issue an m0 read, then assert reset for 1 cycle before its return: no m0_rvalid appears; after reset release, the first contention is granted to m0.

Source files
------------

// File: rtl/fb_port_arbiter.sv
// Two-master arbiter for framebuffer BRAM port A: grants one command per cycle,
// registers it onto the port and returns read data to its owner in order.
module fb_port_arbiter #(
  parameter int ARB_MODE     = 0,
  parameter int MAX_STARVE   = 16,
  parameter int READ_LATENCY = 1,
  parameter int FB_BYTES     = 307200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [3:0]  m0_we,
  input  logic [18:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [3:0]  m1_we,
  input  logic [18:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        bram_clka,
  output logic        bram_rsta,
  output logic        bram_ena,
  output logic [3:0]  bram_wea,
  output logic [18:0] bram_addra,
  output logic [31:0] bram_dina,
  input  logic [31:0] bram_douta
);

  localparam logic [7:0]  STARVE_LIMIT = 8'(MAX_STARVE);
  localparam logic [19:0] FB_LIMIT     = 20'(FB_BYTES);

  typedef struct packed {
    logic valid;
    logic owner;
    logic oob;
  } tag_t;

  logic        last_grant_reg;
  logic [7:0]  starve_reg;
  tag_t        tag_reg [READ_LATENCY+1];

  logic        bram_ena_reg;
  logic [3:0]  bram_wea_reg;
  logic [18:0] bram_addra_reg;
  logic [31:0] bram_dina_reg;
  logic        m0_rvalid_reg, m1_rvalid_reg;
  logic [31:0] m0_rdata_reg, m1_rdata_reg;

  logic        pick_m1;
  logic        grant0, grant1, accept, oob, issue_ok;
  logic [3:0]  sel_we, issue_we;
  logic [18:0] sel_addr;
  logic [31:0] sel_wdata;

  always_comb begin
    pick_m1 = m1_req;
    if (m0_req && m1_req) begin
      if (ARB_MODE == 0) pick_m1 = (last_grant_reg == 1'b0);
      else               pick_m1 = (starve_reg >= STARVE_LIMIT);
    end
    grant0 = !reset && m0_req && !pick_m1;
    grant1 = !reset && m1_req && pick_m1;
  end

  assign accept    = grant0 || grant1;
  assign sel_we    = grant1 ? m1_we    : m0_we;
  assign sel_addr  = grant1 ? m1_addr  : m0_addr;
  assign sel_wdata = grant1 ? m1_wdata : m0_wdata;
  // Out-of-range commands are still accepted, they just never reach the BRAM.
  assign oob       = ({1'b0, sel_addr} >= FB_LIMIT);
  assign issue_ok  = accept && !oob;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign issue_we[gi] = issue_ok && sel_we[gi];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_reg <= 1'b1;
      starve_reg     <= '0;
      bram_ena_reg   <= 1'b0;
      bram_wea_reg   <= '0;
      bram_addra_reg <= '0;
      bram_dina_reg  <= '0;
      m0_rvalid_reg  <= 1'b0;
      m1_rvalid_reg  <= 1'b0;
      m0_rdata_reg   <= '0;
      m1_rdata_reg   <= '0;
      for (int k = 0; k <= READ_LATENCY; k++) tag_reg[k] <= '0;
    end else begin
      if (accept) last_grant_reg <= grant1;

      if (m1_req && !grant1) begin
        if (starve_reg != 8'hFF) starve_reg <= starve_reg + 8'd1;
      end else begin
        starve_reg <= '0;
      end

      bram_ena_reg <= issue_ok;
      bram_wea_reg <= issue_we;
      if (accept) begin
        bram_addra_reg <= sel_addr;
        bram_dina_reg  <= sel_wdata;
      end

      // Slot k describes the command whose BRAM access happened k cycles ago.
      tag_reg[0] <= '{valid: accept && (sel_we == 4'h0), owner: grant1, oob: oob};
      for (int k = 1; k <= READ_LATENCY; k++) tag_reg[k] <= tag_reg[k-1];

      m0_rvalid_reg <= 1'b0;
      m1_rvalid_reg <= 1'b0;
      if (tag_reg[READ_LATENCY].valid) begin
        if (tag_reg[READ_LATENCY].owner) begin
          m1_rvalid_reg <= 1'b1;
          m1_rdata_reg  <= tag_reg[READ_LATENCY].oob ? 32'h0 : bram_douta;
        end else begin
          m0_rvalid_reg <= 1'b1;
          m0_rdata_reg  <= tag_reg[READ_LATENCY].oob ? 32'h0 : bram_douta;
        end
      end
    end
  end

  assign m0_gnt     = grant0;
  assign m1_gnt     = grant1;
  assign m0_rvalid  = m0_rvalid_reg;
  assign m1_rvalid  = m1_rvalid_reg;
  assign m0_rdata   = m0_rdata_reg;
  assign m1_rdata   = m1_rdata_reg;
  assign bram_clka  = clk;
  assign bram_rsta  = reset;
  assign bram_ena   = bram_ena_reg;
  assign bram_wea   = bram_wea_reg;
  assign bram_addra = bram_addra_reg;
  assign bram_dina  = bram_dina_reg;

endmodule
